// File: rtl/nested_sqrt_pipe.sv
// Nested integer square-root pipeline:
//   res = isqrt(x[0] + isqrt(x[1] + ... + isqrt(x[N_LEVELS-1])))
// Accepts one argument set per clock with fixed latency
// L = N_LEVELS*ISQRT_STAGES + (N_LEVELS-1). Saturating adders flag overflow,
// and an in-flight counter with an idle flag supports drain/flush control.

// Pipelined 32-bit integer square root. Each of the 16 digit-recurrence
// iterations is placed in one of N_PIPE_STAGES register stages, so the
// latency is exactly N_PIPE_STAGES cycles. Data registers load only
// together with a valid bit.
module IsqrtPipe #(
    parameter int N_PIPE_STAGES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_x_vld,
    input  logic [31:0] i_x,
    output logic        o_y_vld,
    output logic [31:0] o_y
);
    localparam int ITERS = 16;

    for (genvar j = 0; j < N_PIPE_STAGES; j++) begin : g_stage
        localparam int LO = (j * ITERS) / N_PIPE_STAGES;
        localparam int HI = ((j + 1) * ITERS) / N_PIPE_STAGES;

        logic        w_inVld;
        logic [31:0] w_inRem;
        logic [31:0] w_inRoot;
        logic [31:0] w_rem;
        logic [31:0] w_root;
        logic [31:0] w_trial;
        logic        r_vld;
        logic [31:0] r_rem;
        logic [31:0] r_root;

        if (j == 0) begin : g_head
            assign w_inVld  = i_x_vld;
            assign w_inRem  = i_x;
            assign w_inRoot = '0;
        end else begin : g_body
            assign w_inVld  = g_stage[j-1].r_vld;
            assign w_inRem  = g_stage[j-1].r_rem;
            assign w_inRoot = g_stage[j-1].r_root;
        end

        // Run this stage's share of the bit-by-bit root recurrence
        always_comb begin
            w_rem   = w_inRem;
            w_root  = w_inRoot;
            w_trial = '0;
            for (int it = LO; it < HI; it++) begin
                w_trial = w_root + (32'd1 << (30 - 2 * it));
                if (w_rem >= w_trial) begin
                    w_rem  = w_rem - w_trial;
                    w_root = (w_root >> 1) + (32'd1 << (30 - 2 * it));
                end else begin
                    w_root = w_root >> 1;
                end
            end
        end

        // Stage valid bit, cleared by reset
        always_ff @(posedge i_clk) begin
            if (i_rst) r_vld <= 1'b0;
            else       r_vld <= w_inVld;
        end

        // Stage data registers, only written when a valid sample enters
        always_ff @(posedge i_clk) begin
            if (w_inVld) begin
                r_rem  <= w_rem;
                r_root <= w_root;
            end
        end
    end

    assign o_y_vld = g_stage[N_PIPE_STAGES-1].r_vld;
    assign o_y     = g_stage[N_PIPE_STAGES-1].r_root;

    // The final remainder is not needed by anyone
    logic w_unused_rem;
    assign w_unused_rem = ^g_stage[N_PIPE_STAGES-1].r_rem;
endmodule

module nested_sqrt_pipe #(
    parameter int WIDTH        = 32,
    parameter int N_LEVELS     = 3,
    parameter int ISQRT_STAGES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_arg_vld,
    input  logic [N_LEVELS*WIDTH-1:0] i_args,
    output logic                      o_res_vld,
    output logic [WIDTH-1:0]          o_res,
    output logic                      o_res_ovf,
    output logic [$clog2(N_LEVELS*ISQRT_STAGES+N_LEVELS+1)-1:0] o_in_flight,
    output logic                      o_idle
);
    localparam int L  = N_LEVELS * ISQRT_STAGES + (N_LEVELS - 1);
    localparam int FW = $clog2(L + 2);

    if (WIDTH < 1 || WIDTH > 32) begin : g_badWidth
        $error("nested_sqrt_pipe: WIDTH must be in 1..32");
    end
    if (N_LEVELS < 1) begin : g_badLevels
        $error("nested_sqrt_pipe: N_LEVELS must be at least 1");
    end
    if (ISQRT_STAGES < 1) begin : g_badStages
        $error("nested_sqrt_pipe: ISQRT_STAGES must be at least 1");
    end

    function automatic logic [31:0] widen(input logic [WIDTH-1:0] v);
        logic [31:0] t;
        t = '0;
        t[WIDTH-1:0] = v;
        return t;
    endfunction

    logic [31:0] w_y    [N_LEVELS];
    logic        w_yVld [N_LEVELS];
    logic        w_ovf  [N_LEVELS];

    for (genvar k = 0; k < N_LEVELS; k++) begin : g_level
        if (k == 0) begin : g_root
            // Innermost operand goes straight into the first root
            logic [31:0] w_isqrtIn;
            assign w_isqrtIn = widen(i_args[(N_LEVELS-1)*WIDTH +: WIDTH]);

            IsqrtPipe #(.N_PIPE_STAGES(ISQRT_STAGES)) u_isqrt (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_x_vld (i_arg_vld),
                .i_x     (w_isqrtIn),
                .o_y_vld (w_yVld[0]),
                .o_y     (w_y[0])
            );
            assign w_ovf[0] = 1'b0;
        end else begin : g_add
            // Operand waits D cycles so it meets the previous level's root
            localparam int D = k * (ISQRT_STAGES + 1) - 1;

            logic [D-1:0]            r_opVld;
            logic [WIDTH-1:0]        r_op [D];
            logic [WIDTH:0]          w_sum;
            logic [WIDTH-1:0]        w_sat;
            logic                    r_sumVld;
            logic [WIDTH-1:0]        r_sum;
            logic                    r_sumOvf;
            logic [31:0]             w_isqrtIn;
            logic [ISQRT_STAGES-1:0] r_ovfVld;
            logic                    r_ovfBit [ISQRT_STAGES];

            // Valid tags of the operand delay line
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_opVld <= '0;
                end else begin
                    r_opVld[0] <= i_arg_vld;
                    for (int i = 1; i < D; i++) r_opVld[i] <= r_opVld[i-1];
                end
            end

            // Operand delay line data, each slot written only under its valid
            always_ff @(posedge i_clk) begin
                if (i_arg_vld) r_op[0] <= i_args[(N_LEVELS-1-k)*WIDTH +: WIDTH];
                for (int i = 1; i < D; i++) begin
                    if (r_opVld[i-1]) r_op[i] <= r_op[i-1];
                end
            end

            assign w_sum = {1'b0, r_op[D-1]} + {1'b0, w_y[k-1][WIDTH-1:0]};
            assign w_sat = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];

            // Adder stage valid follows the previous root's valid
            always_ff @(posedge i_clk) begin
                if (i_rst) r_sumVld <= 1'b0;
                else       r_sumVld <= w_yVld[k-1];
            end

            // Saturating adder register, carry-out folded into the overflow tag
            always_ff @(posedge i_clk) begin
                if (w_yVld[k-1]) begin
                    r_sum    <= w_sat;
                    r_sumOvf <= w_ovf[k-1] | w_sum[WIDTH];
                end
            end

            assign w_isqrtIn = widen(r_sum);

            IsqrtPipe #(.N_PIPE_STAGES(ISQRT_STAGES)) u_isqrt (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_x_vld (r_sumVld),
                .i_x     (w_isqrtIn),
                .o_y_vld (w_yVld[k]),
                .o_y     (w_y[k])
            );

            // Overflow side pipe valids, shadowing the root's latency
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_ovfVld <= '0;
                end else begin
                    r_ovfVld[0] <= r_sumVld;
                    for (int j = 1; j < ISQRT_STAGES; j++) r_ovfVld[j] <= r_ovfVld[j-1];
                end
            end

            // Overflow side pipe data, valid-gated like the data path
            always_ff @(posedge i_clk) begin
                if (r_sumVld) r_ovfBit[0] <= r_sumOvf;
                for (int j = 1; j < ISQRT_STAGES; j++) begin
                    if (r_ovfVld[j-1]) r_ovfBit[j] <= r_ovfBit[j-1];
                end
            end

            assign w_ovf[k] = r_ovfBit[ISQRT_STAGES-1];

            // The last tag of each line coincides with a root valid already in use
            logic w_unused_tags;
            assign w_unused_tags = r_opVld[D-1] ^ r_ovfVld[ISQRT_STAGES-1];
        end

        // Root bits above WIDTH are dropped by truncation
        logic w_unused_hi;
        assign w_unused_hi = ^w_y[k];
    end

    assign o_res_vld = w_yVld[N_LEVELS-1];
    assign o_res     = w_y[N_LEVELS-1][WIDTH-1:0];
    assign o_res_ovf = w_ovf[N_LEVELS-1];

    logic [FW-1:0] r_inFlight;

    // Count accepted sets that have not yet produced a result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inFlight <= '0;
        end else begin
            case ({i_arg_vld, o_res_vld})
                2'b10:   r_inFlight <= r_inFlight + FW'(1);
                2'b01:   r_inFlight <= r_inFlight - FW'(1);
                default: r_inFlight <= r_inFlight;
            endcase
        end
    end

    assign o_in_flight = r_inFlight;
    assign o_idle      = (r_inFlight == '0);
endmodule

// File: tb/tb_nested_sqrt_pipe.sv
// Self-checking bench for nested_sqrt_pipe: directed cases plus a randomized
// run compared cycle by cycle against a plain-arithmetic reference model,
// and two extra instances covering other parameter sets.
module tb_nested_sqrt_pipe;
    localparam int W    = 32;
    localparam int N    = 3;
    localparam int S    = 4;
    localparam int L    = N * S + N - 1;
    localparam int FW   = $clog2(L + 2);
    localparam int L1   = 1 * 2 + 0;
    localparam int FW1  = $clog2(L1 + 2);
    localparam int L5   = 5 * 3 + 4;
    localparam int FW5  = $clog2(L5 + 2);
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          argVld = 1'b0;
    logic [N*W-1:0] args = '0;
    logic          resVld;
    logic [W-1:0]  res;
    logic          resOvf;
    logic [FW-1:0] inFlight;
    logic          idle;

    logic          argVld1 = 1'b0;
    logic [15:0]   args1 = '0;
    logic          resVld1;
    logic [15:0]   res1;
    logic          resOvf1;
    logic [FW1-1:0] inFlight1;
    logic          idle1;

    logic          argVld5 = 1'b0;
    logic [159:0]  args5 = '0;
    logic          resVld5;
    logic [31:0]   res5;
    logic          resOvf5;
    logic [FW5-1:0] inFlight5;
    logic          idle5;

    always #5 clk = ~clk;

    nested_sqrt_pipe #(.WIDTH(W), .N_LEVELS(N), .ISQRT_STAGES(S)) dut (
        .i_clk(clk), .i_rst(rst), .i_arg_vld(argVld), .i_args(args),
        .o_res_vld(resVld), .o_res(res), .o_res_ovf(resOvf),
        .o_in_flight(inFlight), .o_idle(idle)
    );

    nested_sqrt_pipe #(.WIDTH(16), .N_LEVELS(1), .ISQRT_STAGES(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_arg_vld(argVld1), .i_args(args1),
        .o_res_vld(resVld1), .o_res(res1), .o_res_ovf(resOvf1),
        .o_in_flight(inFlight1), .o_idle(idle1)
    );

    nested_sqrt_pipe #(.WIDTH(32), .N_LEVELS(5), .ISQRT_STAGES(3)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_arg_vld(argVld5), .i_args(args5),
        .o_res_vld(resVld5), .o_res(res5), .o_res_ovf(resOvf5),
        .o_in_flight(inFlight5), .o_idle(idle5)
    );

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int mdlInFlight = 0;
    int peakInFlight = 0;

    bit          expVld [MAXC];
    logic [31:0] expRes [MAXC];
    bit          expOvf [MAXC];

    int          obsCyc [$];
    logic [31:0] obsRes [$];
    bit          obsOvf [$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Floor square root by binary search
    function automatic longint unsigned refSqrt(input longint unsigned v);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    function automatic longint unsigned opAt(input logic [255:0] a, input int i, input int w);
        logic [255:0] t;
        longint unsigned maxV;
        maxV = (64'd1 << w) - 1;
        t = a >> (i * w);
        return t[63:0] & maxV;
    endfunction

    // Nested root with saturation, evaluated from the innermost operand out
    function automatic longint unsigned refNested(input logic [255:0] a, input int n, input int w,
                                                  output bit ovf);
        longint unsigned maxV, y, s;
        maxV = (64'd1 << w) - 1;
        ovf = 1'b0;
        y = refSqrt(opAt(a, n - 1, w)) & maxV;
        for (int k = 1; k < n; k++) begin
            s = opAt(a, n - 1 - k, w) + y;
            if (s > maxV) begin
                s = maxV;
                ovf = 1'b1;
            end
            y = refSqrt(s) & maxV;
        end
        return y;
    endfunction

    function automatic logic [N*W-1:0] pack3(input logic [31:0] x0, input logic [31:0] x1,
                                              input logic [31:0] x2);
        return {x2, x1, x0};
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 2))
            0:       return 32'($urandom);
            1:       return 32'($urandom_range(0, 1000));
            default: return 32'hFFFF_0000 | (32'($urandom) & 32'h0000_FFFF);
        endcase
    endfunction

    // Drive one cycle of main-DUT inputs, update the model, advance and compare
    task automatic applyStimulus(input bit vld, input logic [N*W-1:0] a, input bit r);
        bit o;
        longint unsigned y;
        rst    = r;
        argVld = vld;
        args   = a;
        if (r) begin
            for (int j = cyc + 1; j < MAXC; j++) expVld[j] = 1'b0;
            mdlInFlight = 0;
        end else begin
            mdlInFlight = mdlInFlight + int'(vld) - int'(expVld[cyc]);
            if (vld) begin
                y = refNested({160'd0, a}, N, W, o);
                expVld[cyc + L] = 1'b1;
                expRes[cyc + L] = 32'(y);
                expOvf[cyc + L] = o;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        checkOutput("res_vld", {63'd0, resVld}, {63'd0, expVld[cyc]});
        if (expVld[cyc]) begin
            checkOutput("res", {32'd0, res}, {32'd0, expRes[cyc]});
            checkOutput("res_ovf", {63'd0, resOvf}, {63'd0, expOvf[cyc]});
        end
        checkOutput("in_flight", 64'(inFlight), 64'(mdlInFlight));
        checkOutput("idle", {63'd0, idle}, {63'd0, mdlInFlight == 0});
        if (int'(inFlight) > peakInFlight) peakInFlight = int'(inFlight);
        if (resVld) begin
            obsCyc.push_back(cyc);
            obsRes.push_back(res);
            obsOvf.push_back(resOvf);
        end
    endtask

    task automatic clearObs();
        obsCyc.delete();
        obsRes.delete();
        obsOvf.delete();
    endtask

    initial begin
        int c0;
        int nSets;
        bit vld;
        bit ovfA, ovfB;
        longint unsigned yA, yB;
        logic [159:0] setA, setB;

        for (int i = 0; i < MAXC; i++) begin
            expVld[i] = 1'b0;
            expRes[i] = '0;
            expOvf[i] = 1'b0;
        end

        $display("[TB] reset");
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("reset_vld", {63'd0, resVld}, 64'd0);
        checkOutput("reset_idle", {63'd0, idle}, 64'd1);

        $display("[TB] single set");
        clearObs();
        c0 = cyc;
        applyStimulus(1'b1, pack3(0, 0, 16), 1'b0);
        repeat (16) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("single_count", 64'(obsCyc.size()), 64'd1);
        if (obsCyc.size() >= 1) begin
            checkOutput("single_lat", 64'(obsCyc[0] - c0), 64'(L));
            checkOutput("single_res", {32'd0, obsRes[0]}, 64'd1);
            checkOutput("single_ovf", {63'd0, obsOvf[0]}, 64'd0);
        end

        $display("[TB] back-to-back sets");
        clearObs();
        c0 = cyc;
        peakInFlight = 0;
        applyStimulus(1'b1, pack3(21, 7, 81), 1'b0);
        applyStimulus(1'b1, pack3(0, 0, 16), 1'b0);
        applyStimulus(1'b1, pack3(3, 0, 0), 1'b0);
        repeat (16) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("b2b_count", 64'(obsCyc.size()), 64'd3);
        if (obsCyc.size() >= 3) begin
            checkOutput("b2b_lat0", 64'(obsCyc[0] - c0), 64'd14);
            checkOutput("b2b_lat1", 64'(obsCyc[1] - c0), 64'd15);
            checkOutput("b2b_lat2", 64'(obsCyc[2] - c0), 64'd16);
            checkOutput("b2b_res0", {32'd0, obsRes[0]}, 64'd5);
            checkOutput("b2b_res1", {32'd0, obsRes[1]}, 64'd1);
            checkOutput("b2b_res2", {32'd0, obsRes[2]}, 64'd1);
        end
        checkOutput("b2b_peak", 64'(peakInFlight), 64'd3);

        $display("[TB] overflow");
        clearObs();
        applyStimulus(1'b1, pack3(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b0);
        applyStimulus(1'b1, pack3(0, 0, 16), 1'b0);
        repeat (16) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ovf_count", 64'(obsCyc.size()), 64'd2);
        if (obsCyc.size() >= 2) begin
            checkOutput("ovf_res0", {32'd0, obsRes[0]}, 64'd255);
            checkOutput("ovf_flag0", {63'd0, obsOvf[0]}, 64'd1);
            checkOutput("ovf_res1", {32'd0, obsRes[1]}, 64'd1);
            checkOutput("ovf_flag1", {63'd0, obsOvf[1]}, 64'd0);
        end

        $display("[TB] reset with sets in flight");
        clearObs();
        c0 = cyc;
        repeat (5) applyStimulus(1'b1, pack3(randOperand(), randOperand(), randOperand()), 1'b0);
        applyStimulus(1'b1, pack3(randOperand(), randOperand(), randOperand()), 1'b1);
        checkOutput("rst_inflight", 64'(inFlight), 64'd0);
        checkOutput("rst_idle", {63'd0, idle}, 64'd1);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, pack3(21, 7, 81), 1'b0);
        repeat (20) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rst_count", 64'(obsCyc.size()), 64'd1);
        if (obsCyc.size() >= 1) begin
            checkOutput("rst_lat", 64'(obsCyc[0] - c0), 64'd21);
            checkOutput("rst_res", {32'd0, obsRes[0]}, 64'd5);
        end

        $display("[TB] random sets with bubbles");
        clearObs();
        nSets = 0;
        while (nSets < 2000) begin
            vld = ($urandom_range(0, 3) != 0);
            applyStimulus(vld, pack3(randOperand(), randOperand(), randOperand()), 1'b0);
            if (vld) nSets++;
        end
        repeat (L + 2) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rand_count", 64'(obsCyc.size()), 64'd2000);

        $display("[TB] N_LEVELS=1 S=2 W=16");
        argVld1 = 1'b1;
        args1   = 16'hFFFF;
        for (int d = 1; d <= 4; d++) begin
            applyStimulus(1'b0, '0, 1'b0);
            argVld1 = 1'b0;
            checkOutput("w16_vld", {63'd0, resVld1}, {63'd0, d == 2});
            checkOutput("w16_inflight", 64'(inFlight1), (d <= 2) ? 64'd1 : 64'd0);
            if (d == 2) begin
                checkOutput("w16_res", {48'd0, res1}, 64'd255);
                checkOutput("w16_ovf", {63'd0, resOvf1}, 64'd0);
            end
        end

        $display("[TB] N_LEVELS=5 S=3 W=32");
        for (int i = 0; i < 5; i++) begin
            setA[i*32 +: 32] = 32'($urandom);
            setB[i*32 +: 32] = 32'($urandom_range(0, 5000));
        end
        yA = refNested({96'd0, setA}, 5, 32, ovfA);
        yB = refNested({96'd0, setB}, 5, 32, ovfB);
        argVld5 = 1'b1;
        args5   = setA;
        for (int d = 1; d <= 22; d++) begin
            applyStimulus(1'b0, '0, 1'b0);
            if (d == 1) args5 = setB;
            if (d == 2) argVld5 = 1'b0;
            checkOutput("n5_vld", {63'd0, resVld5}, {63'd0, (d == L5) || (d == L5 + 1)});
            if (d == L5) begin
                checkOutput("n5_resA", {32'd0, res5}, yA);
                checkOutput("n5_ovfA", {63'd0, resOvf5}, {63'd0, ovfA});
            end
            if (d == L5 + 1) begin
                checkOutput("n5_resB", {32'd0, res5}, yB);
                checkOutput("n5_ovfB", {63'd0, resOvf5}, {63'd0, ovfB});
            end
        end
        checkOutput("n5_idle", {63'd0, idle5}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
